// File: rtl/alu_seq_nbits.sv
// ---------------------------------------------------------------------------
// alu_seq_nbits
//   WIDTH-bit signed/unsigned ALU with registered results and valid/ready
//   handshakes on both sides. Logic and add/subtract-class opcodes finish in
//   one cycle. Shifts and the unsigned multiply iterate one bit per cycle in a
//   small FSM. Only one operation is in flight at a time.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operation handshake; A, B, opt captured on fire
//   A, B                  operands (B[SHW-1:0] is the shift amount for shifts)
//   opt                   opcode 0..15
//   out_valid / out_ready result handshake; result and flags hold while stalled
//   result                WIDTH-bit result
//   carry_out, overflow, zero_flag, less_flag, equal_flag, illegal  status
// ---------------------------------------------------------------------------
module alu_seq_nbits #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       opt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero_flag,
  output logic             less_flag,
  output logic             equal_flag,
  output logic             illegal
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_NOT = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SLT = 4'd6;
  localparam logic [3:0] OP_EQ  = 4'd7;
  localparam logic [3:0] OP_SLL = 4'd8;
  localparam logic [3:0] OP_SRL = 4'd9;
  localparam logic [3:0] OP_SRA = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;

  localparam int MSB = WIDTH - 1;

  logic [1:0]       state;
  logic [SHW:0]     cnt;
  logic [3:0]       op_p0;
  logic [WIDTH-1:0] acc_p0;
  logic [WIDTH-1:0] mcand_p0;
  logic [WIDTH-1:0] mplier_p0;

  logic             fire_in;
  logic [SHW-1:0]   shamt;
  logic             is_shift;
  logic             go_busy;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign fire_in   = in_valid && in_ready;
  assign shamt     = B[SHW-1:0];
  assign is_shift  = (opt == OP_SLL) || (opt == OP_SRL) || (opt == OP_SRA);
  // A zero-length shift completes like a single-cycle op; MUL always iterates.
  assign go_busy   = (opt == OP_MUL) || (is_shift && (shamt != '0));

  // Single-cycle datapath, evaluated on the raw inputs at accept.
  logic [WIDTH:0]     add_w;
  logic [WIDTH:0]     sub_w;
  logic               add_ovf;
  logic               sub_ovf;
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;

  assign a_s     = A;
  assign b_s     = B;
  assign add_w   = {1'b0, A} + {1'b0, B};
  assign sub_w   = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
  assign add_ovf = (a_s[MSB] == b_s[MSB]) && (add_w[MSB] != a_s[MSB]);
  assign sub_ovf = (a_s[MSB] != b_s[MSB]) && (sub_w[MSB] != a_s[MSB]);

  logic [WIDTH-1:0] sc_res;
  logic             sc_c;
  logic             sc_v;
  logic             sc_z;
  logic             sc_lt;
  logic             sc_eq;
  logic             sc_ill;

  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sc_z   = 1'b0;
    sc_lt  = 1'b0;
    sc_eq  = 1'b0;
    sc_ill = 1'b0;
    case (opt)
      OP_ADD: begin
        sc_res = add_w[WIDTH-1:0];
        sc_c   = add_w[WIDTH];
        sc_v   = add_ovf;
        sc_z   = ~|add_w[WIDTH-1:0];
      end
      OP_SUB: begin
        sc_res = sub_w[WIDTH-1:0];
        sc_c   = sub_w[WIDTH];
        sc_v   = sub_ovf;
        sc_z   = ~|sub_w[WIDTH-1:0];
      end
      OP_NOT: begin
        sc_res = ~A;
        sc_z   = ~|(~A);
      end
      OP_AND: begin
        sc_res = A & B;
        sc_z   = ~|(A & B);
      end
      OP_OR: begin
        sc_res = A | B;
        sc_z   = ~|(A | B);
      end
      OP_XOR: begin
        sc_res = A ^ B;
        sc_z   = ~|(A ^ B);
      end
      OP_SLT: begin
        sc_res = sub_w[WIDTH-1:0];
        sc_c   = sub_w[WIDTH];
        sc_v   = sub_ovf;
        // Sign of the true difference: the MSB is wrong exactly when it overflowed.
        sc_lt  = sub_ovf ^ sub_w[MSB];
        sc_z   = ~|sub_w[WIDTH-1:0];
      end
      OP_EQ: begin
        sc_res = sub_w[WIDTH-1:0];
        sc_c   = sub_w[WIDTH];
        sc_v   = sub_ovf;
        sc_eq  = ~|sub_w[WIDTH-1:0];
      end
      OP_SLL, OP_SRL, OP_SRA: begin
        // Only reached with shamt == 0: the operand passes through.
        sc_res = A;
        sc_z   = ~|A;
      end
      OP_MUL: begin
        sc_res = '0;
      end
      default: begin
        sc_ill = 1'b1;
      end
    endcase
  end

  // Iterative step: one shift bit or one multiplier bit per BUSY cycle.
  logic [WIDTH-1:0] acc_nxt;

  always_comb begin
    acc_nxt = acc_p0;
    case (op_p0)
      OP_SLL:  acc_nxt = acc_p0 << 1;
      OP_SRL:  acc_nxt = acc_p0 >> 1;
      OP_SRA:  acc_nxt = {acc_p0[MSB], acc_p0[WIDTH-1:1]};
      OP_MUL:  acc_nxt = mplier_p0[0] ? (acc_p0 + mcand_p0) : acc_p0;
      default: acc_nxt = acc_p0;
    endcase
  end

  // ---- p0: iterative working registers (captured at accept, no reset) ----
  always_ff @(posedge clk) begin
    if (fire_in) begin
      op_p0     <= opt;
      acc_p0    <= (opt == OP_MUL) ? '0 : A;
      mcand_p0  <= A;
      mplier_p0 <= B;
    end else if (state == S_BUSY) begin
      acc_p0    <= acc_nxt;
      mcand_p0  <= mcand_p0 << 1;
      mplier_p0 <= mplier_p0 >> 1;
    end
  end

  // ---- FSM and registered outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      result     <= '0;
      carry_out  <= 1'b0;
      overflow   <= 1'b0;
      zero_flag  <= 1'b0;
      less_flag  <= 1'b0;
      equal_flag <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (go_busy) begin
              state      <= S_BUSY;
              cnt        <= (opt == OP_MUL) ? (SHW+1)'(WIDTH) : {1'b0, shamt};
              carry_out  <= 1'b0;
              overflow   <= 1'b0;
              zero_flag  <= 1'b0;
              less_flag  <= 1'b0;
              equal_flag <= 1'b0;
              illegal    <= 1'b0;
            end else begin
              state      <= S_DONE;
              result     <= sc_res;
              carry_out  <= sc_c;
              overflow   <= sc_v;
              zero_flag  <= sc_z;
              less_flag  <= sc_lt;
              equal_flag <= sc_eq;
              illegal    <= sc_ill;
            end
          end
        end
        S_BUSY: begin
          cnt <= cnt - 1'b1;
          if (cnt == (SHW+1)'(1)) begin
            state     <= S_DONE;
            result    <= acc_nxt;
            zero_flag <= ~|acc_nxt;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_nbits.sv
module tb_alu_seq_nbits;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [3:0]   opt = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         carry_out, overflow, zero_flag, less_flag, equal_flag, illegal;

  alu_seq_nbits #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .opt(opt),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result),
    .carry_out(carry_out), .overflow(overflow), .zero_flag(zero_flag),
    .less_flag(less_flag), .equal_flag(equal_flag), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [5:0]   fl;   // {carry, overflow, zero, less, equal, illegal}
    int           lat;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   tests = 0;
  int   failed = 0;

  function automatic logic [5:0] flags_now();
    return {carry_out, overflow, zero_flag, less_flag, equal_flag, illegal};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] res, input logic [5:0] fl, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.fl = fl; v.lat = lat;
    tbl.push_back(v);
  endtask

  // Issue one op, then wait for its result and check it against the scoreboard.
  // hold > 0 keeps out_ready low for that many cycles once the result appears.
  task automatic do_op(input vec_t v, input int hold, input string tag);
    int   n;
    bit   rdy_ok;
    vec_t e;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_in_ready_wait"}, (n < 20), 1);
    in_valid = 1'b1; opt = v.op; A = v.a; B = v.b;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    in_valid = 1'b0; A = W'($urandom); B = W'($urandom); opt = 4'($urandom);
    rdy_ok = 1'b1;
    n = 1;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      if (in_ready) rdy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, v.lat);
    chk({tag, "_in_ready_busy"}, rdy_ok, 1);
    if (hold > 0) begin
      out_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk({tag, "_hold_valid"}, out_valid, 1);
        chk({tag, "_hold_in_ready"}, in_ready, 0);
        chk({tag, "_hold_result"}, result, exp_q[0].res);
        chk({tag, "_hold_flags"}, flags_now(), exp_q[0].fl);
      end
      out_ready = 1'b1;
    end
    e = exp_q.pop_front();
    chk({tag, "_result"}, result, e.res);
    chk({tag, "_flags"}, flags_now(), e.fl);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;

    // Expected values for WIDTH=8, worked by hand.
    add_vec(4'd0,  8'h7F, 8'h01, 8'h80, 6'b010000, 1); // ADD signed overflow
    add_vec(4'd0,  8'hFF, 8'h01, 8'h00, 6'b101000, 1); // ADD carry, zero
    add_vec(4'd1,  8'h05, 8'h05, 8'h00, 6'b101000, 1); // SUB equal -> zero, no borrow
    add_vec(4'd1,  8'h80, 8'h01, 8'h7F, 6'b110000, 1); // SUB signed overflow
    add_vec(4'd2,  8'hFF, 8'h00, 8'h00, 6'b001000, 1); // NOT -> zero
    add_vec(4'd3,  8'hF0, 8'h3C, 8'h30, 6'b000000, 1); // AND
    add_vec(4'd4,  8'hF0, 8'h0F, 8'hFF, 6'b000000, 1); // OR
    add_vec(4'd5,  8'hAA, 8'hAA, 8'h00, 6'b001000, 1); // XOR -> zero
    add_vec(4'd6,  8'hFE, 8'h01, 8'hFD, 6'b100100, 1); // SLT -2 < 1
    add_vec(4'd6,  8'h01, 8'hFE, 8'h03, 6'b000000, 1); // SLT 1 < -2 false
    add_vec(4'd7,  8'h33, 8'h33, 8'h00, 6'b100010, 1); // EQ
    add_vec(4'd10, 8'h80, 8'h0B, 8'hF0, 6'b000000, 4); // SRA by 3 (upper B bits ignored)
    add_vec(4'd8,  8'h5A, 8'h00, 8'h5A, 6'b000000, 1); // SLL by 0
    add_vec(4'd8,  8'h01, 8'h07, 8'h80, 6'b000000, 8); // SLL by 7
    add_vec(4'd9,  8'h81, 8'h07, 8'h01, 6'b000000, 8); // SRL by 7
    add_vec(4'd11, 8'd13, 8'd11, 8'h8F, 6'b000000, 9); // MUL 13*11
    add_vec(4'd11, 8'h10, 8'h10, 8'h00, 6'b001000, 9); // MUL wraps to zero
    add_vec(4'd14, 8'hFF, 8'hFF, 8'h00, 6'b000001, 1); // illegal opcode

    // Reset state
    #2;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", result, 0);
    chk("reset_flags", flags_now(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      do_op(tbl[i], 0, $sformatf("vec%0d", i));
    end

    // Output backpressure: result held for 5 cycles with in_ready low.
    v.op = 4'd0; v.a = 8'h7F; v.b = 8'h01; v.res = 8'h80; v.fl = 6'b010000; v.lat = 1;
    do_op(v, 5, "hold_add");
    v.op = 4'd14; v.a = 8'h12; v.b = 8'h34; v.res = 8'h00; v.fl = 6'b000001; v.lat = 1;
    do_op(v, 5, "hold_illegal");

    // Reset in the middle of a multiply.
    v.op = 4'd0; v.a = 8'h12; v.b = 8'h34; v.res = 8'h46; v.fl = 6'b000000; v.lat = 1;
    do_op(v, 0, "pre_rst_add");
    @(negedge clk);
    in_valid = 1'b1; opt = 4'd11; A = 8'd13; B = 8'd11;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", result, 0);
    chk("midrst_flags", flags_now(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1);
    v.op = 4'd0; v.a = 8'h03; v.b = 8'h04; v.res = 8'h07; v.fl = 6'b000000; v.lat = 1;
    do_op(v, 0, "post_rst_add");

    chk("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
